alu_seq: RTL and testbench

//  Sequential ALU back-end; consumes the alu_A/alu_B operand pair driven by the execute operand mux.

---
 rtl/alu_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_alu_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: RV64 sequential ALU back-end with an iterative shifter and registered result.
// Define ALU_MUL_EN to build the radix-2 shift-add multiplier for op 10 (MUL/MULW).
module alu_seq #(
  parameter int DATA_WIDTH = 64,
  parameter int SHIFT_STEP = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            alu_op,
  input  logic                  is_word,
  input  logic [DATA_WIDTH-1:0] alu_A,
  input  logic [DATA_WIDTH-1:0] alu_B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  out_illegal
);

  localparam int SW = $clog2(DATA_WIDTH);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t                r_state;
  logic                  r_valid;
  logic                  r_illegal;
  logic [DATA_WIDTH-1:0] r_result;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [CW-1:0]         r_rem;
  logic [3:0]            r_op;
  logic                  r_word;

  function automatic logic [DATA_WIDTH-1:0] sext32(
    input logic [DATA_WIDTH-1:0] v
  );
    return {{(DATA_WIDTH-32){v[31]}}, v[31:0]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] zext32(
    input logic [DATA_WIDTH-1:0] v
  );
    return {{(DATA_WIDTH-32){1'b0}}, v[31:0]};
  endfunction

  logic [DATA_WIDTH-1:0] w_sum;
  logic [DATA_WIDTH-1:0] w_diff;
  logic                  w_slt;
  logic                  w_sltu;
  logic [SW-1:0]         w_shamt;
  logic                  w_is_shift;
  logic                  w_is_mul;
  logic                  w_illegal;
  logic                  w_multi;
  logic [DATA_WIDTH-1:0] w_one;
  logic [DATA_WIDTH-1:0] w_sh_init;

  assign w_sum  = alu_A + alu_B;
  assign w_diff = alu_A - alu_B;
  assign w_slt  = $signed(alu_A) < $signed(alu_B);
  assign w_sltu = alu_A < alu_B;

  assign w_shamt = is_word ? SW'(alu_B[4:0]) : alu_B[SW-1:0];

  assign w_is_shift = (alu_op == OP_SLL) ||
                      (alu_op == OP_SRL) ||
                      (alu_op == OP_SRA);

`ifdef ALU_MUL_EN
  assign w_is_mul  = (alu_op == OP_MUL);
  assign w_illegal = (alu_op > OP_MUL);
`else
  assign w_is_mul  = 1'b0;
  assign w_illegal = (alu_op >= OP_MUL);
`endif

  assign w_multi = w_is_mul ||
                   (w_is_shift && (w_shamt != '0));

  // SRLW shifts the zero-extended word; SLLW/SRAW work on the sign-extended one
  always_comb begin
    w_sh_init = alu_A;
    if (is_word) begin
      if (alu_op == OP_SRL) begin
        w_sh_init = zext32(alu_A);
      end else begin
        w_sh_init = sext32(alu_A);
      end
    end
  end

  always_comb begin
    w_one = '0;
    unique case (alu_op)
      OP_ADD:  w_one = is_word ? sext32(w_sum) : w_sum;
      OP_SUB:  w_one = is_word ? sext32(w_diff) : w_diff;
      OP_SLT:  w_one = {{(DATA_WIDTH-1){1'b0}}, w_slt};
      OP_SLTU: w_one = {{(DATA_WIDTH-1){1'b0}}, w_sltu};
      OP_XOR:  w_one = alu_A ^ alu_B;
      OP_OR:   w_one = alu_A | alu_B;
      OP_AND:  w_one = alu_A & alu_B;
      OP_SLL,
      OP_SRL,
      OP_SRA:  w_one = is_word ? sext32(alu_A) : alu_A;
      default: w_one = '0;
    endcase
  end

  logic [CW-1:0]         w_step;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic                  w_rmul;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_fin_raw;
  logic [DATA_WIDTH-1:0] w_fin;

  assign w_step = (r_rem > CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : r_rem;

  always_comb begin
    w_shifted = r_acc;
    unique case (r_op)
      OP_SLL:  w_shifted = r_acc << w_step;
      OP_SRL:  w_shifted = r_acc >> w_step;
      default: w_shifted = $unsigned($signed(r_acc) >>> w_step);
    endcase
  end

`ifdef ALU_MUL_EN
  logic [DATA_WIDTH-1:0] r_mb;
  logic [DATA_WIDTH-1:0] r_prod;
  logic [DATA_WIDTH-1:0] w_prod_nx;

  assign w_rmul    = (r_op == OP_MUL);
  assign w_prod_nx = r_mb[0] ? (r_prod + r_acc) : r_prod;
  assign w_fin_raw = w_rmul ? w_prod_nx : w_shifted;
`else
  assign w_rmul    = 1'b0;
  assign w_fin_raw = w_shifted;
`endif

  assign w_last = w_rmul ? (r_rem == CW'(1)) : (r_rem == w_step);
  assign w_fin  = r_word ? sext32(w_fin_raw) : w_fin_raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_result  <= '0;
      r_acc     <= '0;
      r_rem     <= '0;
      r_op      <= '0;
      r_word    <= 1'b0;
`ifdef ALU_MUL_EN
      r_mb      <= '0;
      r_prod    <= '0;
`endif
    end else if (flush) begin
      r_state   <= S_IDLE;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op   <= alu_op;
            r_word <= is_word;
            if (w_multi) begin
              r_state <= S_BUSY;
              r_acc   <= w_is_mul ? alu_A : w_sh_init;
              if (w_is_mul) begin
                r_rem <= is_word ? CW'(32) : CW'(DATA_WIDTH);
              end else begin
                r_rem <= CW'(w_shamt);
              end
`ifdef ALU_MUL_EN
              r_mb   <= alu_B;
              r_prod <= '0;
`endif
            end else begin
              r_state   <= S_DONE;
              r_valid   <= 1'b1;
              r_result  <= w_one;
              r_illegal <= w_illegal;
            end
          end
        end
        S_BUSY: begin
          r_acc <= w_rmul ? (r_acc << 1) : w_shifted;
          r_rem <= r_rem - (w_rmul ? CW'(1) : w_step);
`ifdef ALU_MUL_EN
          r_mb   <= r_mb >> 1;
          r_prod <= w_prod_nx;
`endif
          if (w_last) begin
            r_state   <= S_DONE;
            r_valid   <= 1'b1;
            r_result  <= w_fin;
            r_illegal <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = r_valid;
  assign out_illegal = r_illegal;
  assign result      = r_result;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed table-driven bench for alu_seq plus hold/abort sequences.
// Expected values are hand-computed constants for DATA_WIDTH=64, SHIFT_STEP=8.
module tb_alu_seq;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_op = '0;
  logic        is_word = 1'b0;
  logic [63:0] alu_A = '0;
  logic [63:0] alu_B = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic        out_illegal;

  int total = 0;
  int bad = 0;

  alu_seq #(
    .DATA_WIDTH(64),
    .SHIFT_STEP(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .is_word    (is_word),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    logic        ill;
    int          lat;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic w,
                       input logic [63:0] a, input logic [63:0] b);
    in_valid = 1'b1;
    alu_op   = op;
    is_word  = w;
    alu_A    = a;
    alu_B    = b;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    drive(v.op, v.w, v.a, v.b);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({v.nm, " lat"}, 64'(n), 64'(v.lat));
    chk({v.nm, " res"}, result, v.exp);
    chk({v.nm, " ill"}, 64'(out_illegal), 64'(v.ill));
    @(posedge clk);
    #1;
    chk({v.nm, " rdy"}, 64'(in_ready), 64'd1);
    chk({v.nm, " vld0"}, 64'(out_valid), 64'd0);
  endtask

  // Abort a 40-bit SRL at its second BUSY cycle, by rst or by flush.
  task automatic abort_seq(input logic use_rst, input logic [63:0] exp_res);
    int seen;
    @(negedge clk);
    drive(OP_SRL, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd40);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    seen = 0;
    chk("abort busy rdy", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    if (out_valid) seen++;
    if (use_rst) rst = 1'b1;
    else flush = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    flush = 1'b0;
    chk("abort rdy", 64'(in_ready), 64'd1);
    chk("abort res", result, exp_res);
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      @(posedge clk);
      #1;
    end
    chk("abort novld", 64'(seen), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vt.push_back('{"add", OP_ADD, 1'b0, 64'd5, 64'd7, 64'd12, 1'b0, 1});
    vt.push_back('{"sll63", OP_SLL, 1'b0, 64'd1, 64'd63,
                   64'h8000_0000_0000_0000, 1'b0, 9});
    vt.push_back('{"sll0", OP_SLL, 1'b0, 64'h1234, 64'd0,
                   64'h1234, 1'b0, 1});
    vt.push_back('{"sraw", OP_SRA, 1'b1, 64'h0000_0000_8000_0000, 64'd4,
                   64'hFFFF_FFFF_F800_0000, 1'b0, 2});
    vt.push_back('{"slt", OP_SLT, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                   64'd1, 1'b0, 1});
    vt.push_back('{"sltu", OP_SLTU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                   64'd0, 1'b0, 1});
    vt.push_back('{"sltw", OP_SLT, 1'b1, 64'h1_0000_0000, 64'd1,
                   64'd0, 1'b0, 1});
    vt.push_back('{"sub", OP_SUB, 1'b0, 64'd10, 64'd3, 64'd7, 1'b0, 1});
    vt.push_back('{"addw", OP_ADD, 1'b1, 64'h7FFF_FFFF, 64'd1,
                   64'hFFFF_FFFF_8000_0000, 1'b0, 1});
    vt.push_back('{"srl40", OP_SRL, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd40,
                   64'h0000_0000_00FF_FFFF, 1'b0, 6});
    vt.push_back('{"sra17", OP_SRA, 1'b0, 64'h8000_0000_0000_0000, 64'd17,
                   64'hFFFF_C000_0000_0000, 1'b0, 4});
    vt.push_back('{"srlw", OP_SRL, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd4,
                   64'h0000_0000_0800_0000, 1'b0, 2});
    vt.push_back('{"sllw", OP_SLL, 1'b1, 64'd1, 64'd31,
                   64'hFFFF_FFFF_8000_0000, 1'b0, 5});
    vt.push_back('{"sllmask", OP_SLL, 1'b0, 64'd1, 64'h48,
                   64'h100, 1'b0, 2});
    vt.push_back('{"xor", OP_XOR, 1'b0, 64'hF0F0, 64'hFF00,
                   64'h0FF0, 1'b0, 1});
    vt.push_back('{"or", OP_OR, 1'b0, 64'hF0F0, 64'hFF00,
                   64'hFFF0, 1'b0, 1});
    vt.push_back('{"and", OP_AND, 1'b0, 64'hF0F0, 64'hFF00,
                   64'hF000, 1'b0, 1});
    vt.push_back('{"ill12", 4'd12, 1'b0, 64'd5, 64'd7, 64'd0, 1'b1, 1});
`ifdef ALU_MUL_EN
    vt.push_back('{"mul", OP_MUL, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE,
                   64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 65});
    vt.push_back('{"mulw", OP_MUL, 1'b1, 64'h1_0001_0000, 64'h8000,
                   64'hFFFF_FFFF_8000_0000, 1'b0, 33});
`else
    vt.push_back('{"mul", OP_MUL, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE,
                   64'd0, 1'b1, 1});
`endif

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst vld", 64'(out_valid), 64'd0);
    chk("rst ill", 64'(out_illegal), 64'd0);
    chk("rst res", result, 64'd0);
    chk("rst rdy", 64'(in_ready), 64'd1);

    foreach (vt[i]) run_vec(vt[i]);

    // SUB held in DONE while writeback stalls
    @(negedge clk);
    out_ready = 1'b0;
    drive(OP_SUB, 1'b0, 64'd10, 64'd3);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold vld", 64'(out_valid), 64'd1);
      chk("hold res", result, 64'd7);
      chk("hold rdy", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
    end
    chk("hold vld3", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold rel vld", 64'(out_valid), 64'd0);
    chk("hold rel rdy", 64'(in_ready), 64'd1);

    abort_seq(1'b1, 64'd0);

    run_vec('{"add2", OP_ADD, 1'b0, 64'd5, 64'd7, 64'd12, 1'b0, 1});
    abort_seq(1'b0, 64'd12);

    // flush in the same cycle as in_valid must not accept
    @(negedge clk);
    drive(OP_ADD, 1'b0, 64'd1, 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    chk("fl acc rdy", 64'(in_ready), 64'd1);
    chk("fl acc vld", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("fl acc vld2", 64'(out_valid), 64'd0);
    chk("fl acc res", result, 64'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
